// File: rtl/gbe_tx_pkg.sv
// Shared types and constants for the GbE transmit arbiter.
package gbe_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    PAY   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int SEQ_W         = 48;
  localparam int SRC_W         = 3;
  // The word counter is sized for the largest legal packet length
  localparam int PKT_WORDS_MAX = 2048;
  localparam int CNT_W         = $clog2(PKT_WORDS_MAX + 1);

  // Header word: sequence number, reserved byte, source index
  function automatic logic [63:0] make_header(input logic [SEQ_W-1:0] seq,
                                              input logic [SRC_W-1:0] src);
    return {seq, 8'h00, 5'd0, src};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last', wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from last+1 around to last itself; first hit wins
  always_comb begin
    int j;
    j     = 0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last) + k) % N;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/gbe_tx_arbiter.sv
// Round-robin packet scheduler feeding one 10GbE TX port from N_SRC sources.
// Each packet is a header word followed by PKT_WORDS payload words.
//
// state | meaning
// IDLE  | waiting for enable and a ready source; grant latched on exit
// HDR   | inject header token once tx_afull is low
// PAY   | read one payload word per non-throttled cycle
// DRAIN | wait for the EOF word to reach the tx_* registers
module gbe_tx_arbiter
  import gbe_tx_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int PKT_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_SRC-1:0]  src_ready,
  output logic [N_SRC-1:0]  src_rd,
  input  logic [64*N_SRC-1:0] src_data,
  input  logic [31:0]       dest_ip,
  input  logic [15:0]       dest_port_base,
  output logic              tx_valid,
  output logic [63:0]       tx_data,
  output logic              tx_end_of_frame,
  output logic [31:0]       tx_dest_ip,
  output logic [15:0]       tx_dest_port,
  input  logic              tx_afull,
  input  logic              tx_overflow,
  output logic              busy,
  output logic [31:0]       pkt_count,
  output logic              overflow_seen
);

  state_t           state;
  logic [SRC_W-1:0] grant;
  logic [SRC_W-1:0] last_grant;
  logic [CNT_W-1:0] word_cnt;
  logic [SEQ_W-1:0] seq;
  logic             s1_hdr;
  logic             s1_rd;
  logic             s1_last;
  logic [SRC_W-1:0] pick_idx;
  logic             pick_valid;
  logic             rd_en;

  rr_arbiter #(
    .N     (N_SRC),
    .IDX_W (SRC_W)
  ) u_rr (
    .req   (src_ready),
    .last  (last_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // The read strobe must follow tx_afull in the same cycle to bound in-flight words
  assign rd_en  = (state == PAY) && !tx_afull;
  assign src_rd = rd_en ? (N_SRC'(1) << grant) : '0;
  assign busy   = (state != IDLE);

  // Control FSM: grant, header injection, payload reads, drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= SRC_W'(N_SRC - 1);
      word_cnt     <= '0;
      tx_dest_ip   <= '0;
      tx_dest_port <= '0;
      s1_hdr       <= 1'b0;
      s1_rd        <= 1'b0;
      s1_last      <= 1'b0;
    end else begin
      s1_hdr  <= 1'b0;
      s1_rd   <= 1'b0;
      s1_last <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && pick_valid) begin
            grant        <= pick_idx;
            tx_dest_ip   <= dest_ip;
            tx_dest_port <= dest_port_base + 16'(pick_idx);
            word_cnt     <= '0;
            state        <= HDR;
          end
        end
        HDR: begin
          if (!tx_afull) begin
            s1_hdr <= 1'b1;
            state  <= PAY;
          end
        end
        PAY: begin
          if (!tx_afull) begin
            s1_rd    <= 1'b1;
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == CNT_W'(PKT_WORDS - 1)) begin
              s1_last <= 1'b1;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (tx_end_of_frame) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: header or FIFO data (valid the cycle after src_rd) onto tx_*
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_valid        <= 1'b0;
      tx_data         <= '0;
      tx_end_of_frame <= 1'b0;
      seq             <= '0;
      pkt_count       <= '0;
      overflow_seen   <= 1'b0;
    end else begin
      tx_valid        <= s1_hdr | s1_rd;
      tx_end_of_frame <= s1_rd & s1_last;
      if (s1_hdr) begin
        tx_data <= make_header(seq, grant);
        seq     <= seq + 1'b1;
      end else if (s1_rd) begin
        tx_data <= src_data[64*int'(grant) +: 64];
      end else begin
        tx_data <= '0;
      end
      if (s1_rd && s1_last) pkt_count <= pkt_count + 1'b1;
      overflow_seen <= overflow_seen | tx_overflow;
    end
  end

endmodule

// File: tb/tb_gbe_tx_arbiter.sv
// Directed bench for gbe_tx_arbiter with N_SRC=4, PKT_WORDS=4.
module tb_gbe_tx_arbiter;

  localparam int N = 4;
  localparam int P = 4;
  localparam logic [31:0] IP   = 32'hC0A8_0A01;
  localparam logic [15:0] BASE = 16'd7000;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           enable = 1'b0;
  logic [N-1:0]   src_ready = '0;
  logic [N-1:0]   src_rd;
  logic [64*N-1:0] src_data;
  logic [31:0]    dest_ip = IP;
  logic [15:0]    dest_port_base = BASE;
  logic           tx_valid;
  logic [63:0]    tx_data;
  logic           tx_end_of_frame;
  logic [31:0]    tx_dest_ip;
  logic [15:0]    tx_dest_port;
  logic           tx_afull = 1'b0;
  logic           tx_overflow = 1'b0;
  logic           busy;
  logic [31:0]    pkt_count;
  logic           overflow_seen;

  int vec = 0;
  int errs = 0;
  int orphan_eof = 0;
  int rd_cnt [N];

  typedef struct packed {
    logic [63:0] d;
    logic        eof;
    logic [15:0] port;
    logic [31:0] ip;
  } word_t;

  word_t q[$];

  gbe_tx_arbiter #(.N_SRC(N), .PKT_WORDS(P)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .src_ready       (src_ready),
    .src_rd          (src_rd),
    .src_data        (src_data),
    .dest_ip         (dest_ip),
    .dest_port_base  (dest_port_base),
    .tx_valid        (tx_valid),
    .tx_data         (tx_data),
    .tx_end_of_frame (tx_end_of_frame),
    .tx_dest_ip      (tx_dest_ip),
    .tx_dest_port    (tx_dest_port),
    .tx_afull        (tx_afull),
    .tx_overflow     (tx_overflow),
    .busy            (busy),
    .pkt_count       (pkt_count),
    .overflow_seen   (overflow_seen)
  );

  always #5 clk = ~clk;

  // Source FIFOs: read-latency 1, word value = src*256 + reads_so_far + 1
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) rd_cnt[i] <= 0;
      src_data <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (src_rd[i]) begin
          src_data[i*64 +: 64] <= 64'(i*256 + rd_cnt[i] + 1);
          rd_cnt[i] <= rd_cnt[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && tx_valid) q.push_back(word_t'{tx_data, tx_end_of_frame, tx_dest_port, tx_dest_ip});
    if (rst && tx_end_of_frame && !tx_valid) orphan_eof++;
  end

  function automatic logic [63:0] hdr(input int s, input int g);
    return {48'(s), 8'h00, 5'd0, 3'(g)};
  endfunction

  task automatic wait_pkt(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (q.size() >= P + 1) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_busy(input logic val, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (busy === val) begin ok = 1'b1; return; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    src_ready = '0;
    tx_afull = 1'b0;
    tx_overflow = 1'b0;
    repeat (2) @(posedge clk);
    q.delete();
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vec++;
    if ({tx_valid, tx_end_of_frame, src_rd, busy, overflow_seen} !== '0) begin
      errs++;
      $display("FAIL reset_flags: got v=%b eof=%b rd=%b busy=%b ovf=%b, want all 0",
               tx_valid, tx_end_of_frame, src_rd, busy, overflow_seen);
    end
    vec++;
    if ({tx_data, tx_dest_ip, tx_dest_port, pkt_count} !== '0) begin
      errs++;
      $display("FAIL reset_values: got data=%h ip=%h port=%0d cnt=%0d, want 0",
               tx_data, tx_dest_ip, tx_dest_port, pkt_count);
    end
    @(posedge clk); #1 rst = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    word_t w;
    src_ready = 4'b0001;
    wait_busy(1'b1, ok);
    src_ready = '0;
    wait_pkt(ok);
    vec++;
    if (!ok) begin
      errs++; $display("FAIL single_timeout: got %0d words, want %0d", q.size(), P + 1);
    end else begin
      w = q.pop_front();
      vec++;
      if (w.d !== hdr(0, 0)) begin
        errs++; $display("FAIL single_hdr: got %h, want %h", w.d, hdr(0, 0));
      end
      vec++;
      if ({w.port, w.ip} !== {BASE, IP}) begin
        errs++; $display("FAIL single_dest: got port=%0d ip=%h, want %0d %h", w.port, w.ip, BASE, IP);
      end
      for (int k = 0; k < P; k++) begin
        w = q.pop_front();
        vec++;
        if ({w.eof, w.d} !== {k == P - 1, 64'(k + 1)}) begin
          errs++; $display("FAIL single_word%0d: got eof=%b d=%h, want eof=%b d=%0d",
                           k, w.eof, w.d, k == P - 1, k + 1);
        end
      end
    end
    wait_busy(1'b0, ok);
    vec++;
    if (pkt_count !== 32'd1) begin
      errs++; $display("FAIL single_pkt_count: got %0d, want 1", pkt_count);
    end
  endtask

  task automatic test_all();
    bit ok;
    word_t w;
    int g;
    do_reset();
    src_ready = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      g = n % N;
      wait_pkt(ok);
      if (n == 4) src_ready = '0;
      vec++;
      if (!ok) begin
        errs++; $display("FAIL all_timeout_pkt%0d: got %0d words, want %0d", n, q.size(), P + 1);
      end else begin
        w = q.pop_front();
        vec++;
        if ({w.d, w.port} !== {hdr(n, g), 16'(BASE + g)}) begin
          errs++; $display("FAIL all_hdr_pkt%0d: got %h port=%0d, want %h port=%0d",
                           n, w.d, w.port, hdr(n, g), BASE + g);
        end
        for (int k = 0; k < P; k++) begin
          w = q.pop_front();
          vec++;
          if ({w.eof, w.port, w.d} !== {k == P - 1, 16'(BASE + g), 64'(g*256 + (n/N)*P + k + 1)}) begin
            errs++; $display("FAIL all_pkt%0d_word%0d: got eof=%b port=%0d d=%h, want eof=%b port=%0d d=%h",
                             n, k, w.eof, w.port, w.d, k == P - 1, BASE + g, 64'(g*256 + (n/N)*P + k + 1));
          end
        end
      end
    end
    wait_busy(1'b0, ok);
    vec++;
    if (pkt_count !== 32'd5) begin
      errs++; $display("FAIL all_pkt_count: got %0d, want 5", pkt_count);
    end
  endtask

  task automatic test_afull();
    bit ok;
    word_t w;
    int rd_viol = 0;
    int valid_in_pulse = 0;
    do_reset();
    src_ready = 4'b0001;
    wait_busy(1'b1, ok);
    src_ready = '0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (src_rd[0] === 1'b1) ok = 1'b1;
    end
    vec++;
    if (!ok) begin
      errs++; $display("FAIL afull_first_read: got no src_rd, want one");
    end
    @(posedge clk); #1 tx_afull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (src_rd !== '0) rd_viol++;
      if (tx_valid === 1'b1) valid_in_pulse++;
    end
    @(posedge clk); #1 tx_afull = 1'b0;
    vec++;
    if (rd_viol !== 0) begin
      errs++; $display("FAIL afull_rd_blocked: got %0d reads under afull, want 0", rd_viol);
    end
    vec++;
    if (valid_in_pulse > 2) begin
      errs++; $display("FAIL afull_inflight: got %0d words after rise, want <= 2", valid_in_pulse);
    end
    wait_pkt(ok);
    vec++;
    if (!ok) begin
      errs++; $display("FAIL afull_timeout: got %0d words, want %0d", q.size(), P + 1);
    end else begin
      w = q.pop_front();
      vec++;
      if (w.d !== hdr(0, 0)) begin
        errs++; $display("FAIL afull_hdr: got %h, want %h", w.d, hdr(0, 0));
      end
      for (int k = 0; k < P; k++) begin
        w = q.pop_front();
        vec++;
        if ({w.eof, w.d} !== {k == P - 1, 64'(k + 1)}) begin
          errs++; $display("FAIL afull_word%0d: got eof=%b d=%h, want eof=%b d=%0d",
                           k, w.eof, w.d, k == P - 1, k + 1);
        end
      end
    end
    wait_busy(1'b0, ok);
    vec++;
    if (q.size() !== 0) begin
      errs++; $display("FAIL afull_extra_words: got %0d, want 0", q.size());
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    word_t w;
    do_reset();
    src_ready = 4'b1111;
    wait_busy(1'b1, ok);
    enable = 1'b0;
    wait_pkt(ok);
    vec++;
    if (!ok) begin
      errs++; $display("FAIL endrop_timeout: got %0d words, want %0d", q.size(), P + 1);
    end else begin
      for (int k = 0; k <= P; k++) w = q.pop_front();
      vec++;
      if ({w.eof, w.d} !== {1'b1, 64'(P)}) begin
        errs++; $display("FAIL endrop_last: got eof=%b d=%h, want eof=1 d=%0d", w.eof, w.d, P);
      end
    end
    repeat (20) @(negedge clk);
    vec++;
    if ({busy, 8'(q.size())} !== 9'd0) begin
      errs++; $display("FAIL endrop_no_grant: got busy=%b words=%0d, want 0 0", busy, q.size());
    end
    vec++;
    if (pkt_count !== 32'd1) begin
      errs++; $display("FAIL endrop_pkt_count: got %0d, want 1", pkt_count);
    end
    src_ready = '0;
    enable = 1'b1;
  endtask

  task automatic test_midreset();
    bit ok;
    word_t w;
    do_reset();
    src_ready = 4'b0001;
    wait_busy(1'b1, ok);
    src_ready = '0;
    wait_pkt(ok);
    wait_busy(1'b0, ok);
    q.delete();
    src_ready = 4'b0001;
    wait_busy(1'b1, ok);
    src_ready = '0;
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      if (tx_valid === 1'b1 && tx_data === 64'd6) ok = 1'b1;
    end
    vec++;
    if (!ok) begin
      errs++; $display("FAIL midrst_word2_seen: got none, want data 6");
    end
    #1 rst = 1'b0;
    #1;
    vec++;
    if ({tx_valid, tx_end_of_frame, busy, src_rd} !== '0) begin
      errs++; $display("FAIL midrst_flags: got v=%b eof=%b busy=%b rd=%b, want 0",
                       tx_valid, tx_end_of_frame, busy, src_rd);
    end
    vec++;
    if ({tx_data, pkt_count, tx_dest_port} !== '0) begin
      errs++; $display("FAIL midrst_values: got data=%h cnt=%0d port=%0d, want 0",
                       tx_data, pkt_count, tx_dest_port);
    end
    @(posedge clk);
    q.delete();
    #1 rst = 1'b1;
    src_ready = 4'b0001;
    wait_busy(1'b1, ok);
    src_ready = '0;
    wait_pkt(ok);
    vec++;
    if (!ok) begin
      errs++; $display("FAIL midrst_timeout: got %0d words, want %0d", q.size(), P + 1);
    end else begin
      w = q.pop_front();
      vec++;
      if (w.d !== hdr(0, 0)) begin
        errs++; $display("FAIL midrst_hdr: got %h, want %h", w.d, hdr(0, 0));
      end
      for (int k = 0; k < P; k++) begin
        w = q.pop_front();
        vec++;
        if ({w.eof, w.d} !== {k == P - 1, 64'(k + 1)}) begin
          errs++; $display("FAIL midrst_word%0d: got eof=%b d=%h, want eof=%b d=%0d",
                           k, w.eof, w.d, k == P - 1, k + 1);
        end
      end
    end
    wait_busy(1'b0, ok);
  endtask

  task automatic test_overflow();
    bit ok;
    word_t w;
    @(posedge clk); #1 tx_overflow = 1'b1;
    @(negedge clk);
    vec++;
    if (overflow_seen !== 1'b0) begin
      errs++; $display("FAIL ovf_early: got %b, want 0", overflow_seen);
    end
    @(posedge clk); #1 tx_overflow = 1'b0;
    @(negedge clk);
    vec++;
    if (overflow_seen !== 1'b1) begin
      errs++; $display("FAIL ovf_set: got %b, want 1", overflow_seen);
    end
    src_ready = 4'b0010;
    wait_busy(1'b1, ok);
    src_ready = '0;
    wait_pkt(ok);
    vec++;
    if (!ok) begin
      errs++; $display("FAIL ovf_pkt_timeout: got %0d words, want %0d", q.size(), P + 1);
    end else begin
      w = q.pop_front();
      vec++;
      if ({w.d, w.port} !== {hdr(1, 1), 16'(BASE + 1)}) begin
        errs++; $display("FAIL ovf_pkt_hdr: got %h port=%0d, want %h port=%0d",
                         w.d, w.port, hdr(1, 1), BASE + 1);
      end
      q.delete();
    end
    wait_busy(1'b0, ok);
    vec++;
    if (overflow_seen !== 1'b1) begin
      errs++; $display("FAIL ovf_sticky: got %b, want 1", overflow_seen);
    end
    do_reset();
    @(negedge clk);
    vec++;
    if (overflow_seen !== 1'b0) begin
      errs++; $display("FAIL ovf_cleared: got %b, want 0", overflow_seen);
    end
    vec++;
    if (orphan_eof !== 0) begin
      errs++; $display("FAIL eof_without_valid: got %0d, want 0", orphan_eof);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all();
    test_afull();
    test_enable_drop();
    test_midreset();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
